// File: rtl/manchester_tx_arbiter_if.sv
// Requester/line bundle for the Manchester transmit arbiter.
// The master side drives requests and enable; the slave side (the arbiter) drives grants and the line.
interface manchester_tx_arbiter_if;
  logic        en;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        line_out;
  logic        busy;
  logic        frame_done;

  modport master (
    output en, req_valid, req_data,
    input  req_ready, line_out, busy, frame_done
  );

  modport slave (
    input  en, req_valid, req_data,
    output req_ready, line_out, busy, frame_done
  );
endinterface

// File: rtl/manchester_tx_arbiter.sv
// Round-robin 4-requester arbiter feeding a 12-bit Manchester framer (start, ID, data, even parity).
// Grant is combinational in IDLE; each frame is 24 clk of line time followed by a 2*GAP_BITS clk idle gap.
module manchester_tx_arbiter #(
  parameter int GAP_BITS = 1
) (
  input logic               clk,
  input logic               rst,
  manchester_tx_arbiter_if.slave bus
);

  localparam int GAP_CYCLES = 2 * GAP_BITS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t      state, state_d;
  logic [11:0] frame, frame_d;
  logic [3:0]  bit_idx, bit_idx_d;
  logic        half, half_d;
  logic [2:0]  gap_cnt, gap_cnt_d;
  logic [1:0]  last_grant, last_grant_d;
  logic        line, line_d;
  logic        done, done_d;

  logic [1:0]  cand;
  logic [1:0]  grant_id;
  logic        grant_any;
  logic [7:0]  grant_data;
  logic        parity;
  logic        transfer;

  // Search starts just after the previous winner and wraps through all four.
  always_comb begin
    cand      = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      cand = last_grant + 2'(i);
      if (!grant_any && bus.req_valid[cand]) begin
        grant_any = 1'b1;
        grant_id  = cand;
      end
    end
  end

  assign transfer      = (state == IDLE) && bus.en && !rst && grant_any;
  assign bus.req_ready = transfer ? (4'b0001 << grant_id) : 4'b0000;
  assign grant_data    = bus.req_data[{grant_id, 3'b000} +: 8];
  assign parity        = ^{grant_id, grant_data};

  always_comb begin
    state_d      = state;
    frame_d      = frame;
    bit_idx_d    = bit_idx;
    half_d       = half;
    gap_cnt_d    = gap_cnt;
    last_grant_d = last_grant;
    line_d       = 1'b0;
    done_d       = 1'b0;
    case (state)
      IDLE: begin
        if (transfer) begin
          state_d      = SEND;
          frame_d      = {1'b1, grant_id, grant_data, parity};
          bit_idx_d    = '0;
          half_d       = 1'b0;
          last_grant_d = grant_id;
          line_d       = 1'b1;
        end
      end
      SEND: begin
        // frame[11] always holds the bit currently on the line.
        if (!half) begin
          half_d = 1'b1;
          line_d = ~frame[11];
          done_d = (bit_idx == 4'd11);
        end else if (bit_idx == 4'd11) begin
          state_d   = GAP;
          gap_cnt_d = '0;
          half_d    = 1'b0;
          bit_idx_d = '0;
        end else begin
          half_d    = 1'b0;
          bit_idx_d = bit_idx + 4'd1;
          frame_d   = {frame[10:0], 1'b0};
          line_d    = frame[10];
        end
      end
      GAP: begin
        if (gap_cnt == 3'(GAP_CYCLES - 1)) begin
          state_d   = IDLE;
          gap_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_cnt + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      frame      <= '0;
      bit_idx    <= '0;
      half       <= 1'b0;
      gap_cnt    <= '0;
      last_grant <= 2'd3;
      line       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_d;
      frame      <= frame_d;
      bit_idx    <= bit_idx_d;
      half       <= half_d;
      gap_cnt    <= gap_cnt_d;
      last_grant <= last_grant_d;
      line       <= line_d;
      done       <= done_d;
    end
  end

  assign bus.line_out   = line;
  assign bus.busy       = (state != IDLE);
  assign bus.frame_done = done;

endmodule

// File: tb/tb_manchester_tx_arbiter.sv
// Scoreboard bench for manchester_tx_arbiter: stimulus queues expected grants/frames, a negedge monitor checks the line.
module tb_manchester_tx_arbiter;
  localparam int GAP_BITS = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  manchester_tx_arbiter_if bus();

  manchester_tx_arbiter #(.GAP_BITS(GAP_BITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [3:0]  grant;
    logic [11:0] frame;
    int          abort_cyc;
    int          spacing;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  int   checks = 0;
  int   failures = 0;
  int   n_xfer = 0;
  int   fc = 0;
  int   cyc = 0;
  int   last_cyc = 0;
  bit   mon_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic void push(input logic [3:0] g, input logic [11:0] f, input int ab, input int sp);
    exp_t e;
    e.grant = g; e.frame = f; e.abort_cyc = ab; e.spacing = sp;
    q.push_back(e);
  endfunction

  // Monitor: fc counts frame cycles (1..24) then gap cycles; 0 means the DUT should be idle.
  initial begin : monitor
    logic [3:0] xfer;
    logic       expb;
    bit         idle;
    forever begin
      @(negedge clk);
      cyc++;
      if (mon_on) begin
        idle = (fc == 0);
        if (fc > 0) begin
          if (cur.abort_cyc != 0 && fc == cur.abort_cyc + 1) begin
            chk("abort_line", bus.line_out, 0);
            chk("abort_busy", bus.busy, 0);
            chk("abort_done", bus.frame_done, 0);
            fc = 0;
            idle = 1'b1;
          end else if (fc <= 24) begin
            expb = cur.frame[11 - (fc - 1) / 2] ^ ((fc - 1) % 2 != 0);
            chk($sformatf("line_c%0d", fc), bus.line_out, expb);
            chk("frame_done", bus.frame_done, fc == 24);
            chk("busy_send", bus.busy, 1);
            chk("ready_send", bus.req_ready, 0);
            fc++;
          end else begin
            chk("gap_line", bus.line_out, 0);
            chk("gap_busy", bus.busy, 1);
            chk("gap_done", bus.frame_done, 0);
            fc = (fc == 24 + 2 * GAP_BITS) ? 0 : fc + 1;
          end
        end
        if (idle) begin
          xfer = bus.req_ready & bus.req_valid;
          if (rst || !bus.en) chk("ready_blocked", bus.req_ready, 0);
          chk("idle_line", bus.line_out, 0);
          chk("idle_busy", bus.busy, 0);
          chk("idle_done", bus.frame_done, 0);
          if (xfer != 4'b0000) begin
            if (q.size() == 0) begin
              chk("unexpected_grant", xfer, 0);
            end else begin
              cur = q.pop_front();
              chk("grant", bus.req_ready, cur.grant);
              if (cur.spacing != 0) chk("spacing", cyc - last_cyc, cur.spacing);
              last_cyc = cyc;
              n_xfer++;
              fc = 1;
            end
          end
        end
      end
    end
  end

  // Returns #1 after the edge on which transfer number 'target' happens.
  task automatic wait_xfer(input int target);
    int t = 0;
    while (n_xfer < target && t < 200) begin
      @(posedge clk);
      t++;
    end
    chk("xfer_wait", n_xfer >= target, 1);
    #1;
  endtask

  task automatic drain();
    int t = 0;
    while ((q.size() != 0 || fc != 0) && t < 300) begin
      @(posedge clk);
      t++;
    end
    chk("drain", (q.size() == 0 && fc == 0), 1);
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int base;
    rst = 1'b1;
    bus.en = 1'b0;
    bus.req_valid = '0;
    bus.req_data = '0;
    @(posedge clk); #1 mon_on = 1'b1;
    @(posedge clk); #1 rst = 1'b0;

    // Single frame from requester 2, data 0xA5.
    bus.req_data = 32'h00A5_0000;
    bus.en = 1'b1;
    base = n_xfer;
    push(4'b0100, 12'hD4B, 0, 0);
    bus.req_valid = 4'b0100;
    wait_xfer(base + 1);
    bus.req_valid = '0;
    drain();

    // Reset with requests pending, then all four contend: 0,1,2,3,0 at 27-clk spacing.
    rst = 1'b1;
    bus.req_data = 32'h3322_1100;
    bus.req_valid = 4'b1111;
    repeat (2) @(posedge clk);
    #1;
    base = n_xfer;
    push(4'b0001, 12'h800, 0, 0);
    push(4'b0010, 12'hA23, 0, 27);
    push(4'b0100, 12'hC45, 0, 27);
    push(4'b1000, 12'hE66, 0, 27);
    push(4'b0001, 12'h800, 0, 27);
    rst = 1'b0;
    wait_xfer(base + 5);
    bus.req_valid = '0;
    drain();

    // Pointer wrap: grant 1, then 1 and 3 contend -> 3, then 1.
    base = n_xfer;
    push(4'b0010, 12'hA23, 0, 0);
    bus.req_valid = 4'b0010;
    wait_xfer(base + 1);
    bus.req_valid = 4'b1010;
    push(4'b1000, 12'hE66, 0, 27);
    push(4'b0010, 12'hA23, 0, 27);
    wait_xfer(base + 3);
    bus.req_valid = '0;
    drain();

    // en low blocks grants; en dropped in frame cycle 5 lets the frame finish and parks IDLE.
    bus.req_data = 32'h0000_005A;
    bus.en = 1'b0;
    bus.req_valid = 4'b0001;
    base = n_xfer;
    repeat (10) @(posedge clk);
    #1;
    chk("en_low_hold", n_xfer, base);
    push(4'b0001, 12'h8B4, 0, 0);
    bus.en = 1'b1;
    wait_xfer(base + 1);
    repeat (4) @(posedge clk);
    #1 bus.en = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("en_park", n_xfer, base + 1);
    push(4'b0001, 12'h8B4, 0, 0);
    bus.en = 1'b1;
    wait_xfer(base + 2);
    bus.req_valid = '0;
    drain();

    // Reset in frame cycle 10 aborts; afterwards requester 0 beats requester 2.
    bus.req_data = 32'h00A5_0000;
    base = n_xfer;
    push(4'b0100, 12'hD4B, 10, 0);
    push(4'b0001, 12'h800, 0, 0);
    bus.req_valid = 4'b0100;
    wait_xfer(base + 1);
    bus.req_valid = 4'b0101;
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    wait_xfer(base + 2);
    bus.req_valid = '0;
    drain();

    // Requester 3, data 0xFF: parity bit 0.
    bus.req_data = 32'hFF00_0000;
    base = n_xfer;
    push(4'b1000, 12'hFFE, 0, 0);
    bus.req_valid = 4'b1000;
    wait_xfer(base + 1);
    bus.req_valid = '0;
    drain();

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
